v7404_tester: RTL and testbench

Self-checking stimulus/response sequencer for the 7404 hex inverter. Drives the six inverter input pins with a fixed four-vector pattern, waits a programmable settle time per vector, samples the six output pins and flags every gate whose output is not the inverse of its input. It sits opposite the inverter's pin interface: its outputs feed pins 1/3/5/9/11/13, and it reads pins 2/4/6/8/10/12.

---
 rtl/v7404_tester.sv | 139 +++++++++++++
 tb/tb_v7404_tester.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/v7404_tester.sv
// Stimulus/response sequencer for a 7404 hex inverter: walks four vectors and flags mismatching gates.
// Optional: define V7404_TESTER_SYNC_EN to put a 2-flop synchronizer on the response pins (needs SETTLE_CYCLES >= 3).
module v7404_tester #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start,
  output logic       o_pin1,
  output logic       o_pin3,
  output logic       o_pin5,
  output logic       o_pin9,
  output logic       o_pin11,
  output logic       o_pin13,
  input  logic       i_pin2,
  input  logic       i_pin4,
  input  logic       i_pin6,
  input  logic       i_pin8,
  input  logic       i_pin10,
  input  logic       i_pin12,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_pass,
  output logic [5:0] o_fail_mask
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;

  state_t        state;
  logic [1:0]    idx;
  logic [CW-1:0] cnt;
  logic [5:0]    pins;
  logic [5:0]    resp_raw;
  logic [5:0]    resp;
  logic [5:0]    miss;

  function automatic logic [5:0] vec(input logic [1:0] k);
    case (k)
      2'd0:    vec = 6'b000000;
      2'd1:    vec = 6'b111111;
      2'd2:    vec = 6'b010101;
      default: vec = 6'b101010;
    endcase
  endfunction

  assign resp_raw = {i_pin12, i_pin10, i_pin8, i_pin6, i_pin4, i_pin2};

`ifdef V7404_TESTER_SYNC_EN
  logic [5:0] sync_p0;
  logic [5:0] sync_p1;

  generate
    if (SETTLE_CYCLES < 3) begin : g_bad_settle
      $error("SETTLE_CYCLES must be >= 3 when the response synchronizer is enabled");
    end
  endgenerate

  // Synchronizer stage boundary: the value compared lags the pins by two cycles
  always_ff @(posedge i_clk) begin
    sync_p0 <= resp_raw;
    sync_p1 <= sync_p0;
  end

  assign resp = sync_p1;
`else
  generate
    if (SETTLE_CYCLES < 1) begin : g_bad_settle
      $error("SETTLE_CYCLES must be >= 1");
    end
  endgenerate

  assign resp = resp_raw;
`endif

  // A healthy gate drives the inverse of its input
  assign miss = resp ^ ~vec(idx);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state       <= IDLE;
      idx         <= 2'd0;
      cnt         <= '0;
      pins        <= 6'b000000;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_pass      <= 1'b0;
      o_fail_mask <= 6'b000000;
    end else begin
      case (state)
        IDLE: begin
          o_done <= 1'b0;
          pins   <= 6'b000000;
          if (i_start) begin
            state       <= APPLY;
            idx         <= 2'd0;
            cnt         <= '0;
            pins        <= vec(2'd0);
            o_busy      <= 1'b1;
            o_pass      <= 1'b0;
            o_fail_mask <= 6'b000000;
          end
        end
        APPLY: begin
          if (cnt == LAST) begin
            cnt         <= '0;
            o_fail_mask <= o_fail_mask | miss;
            if (idx != 2'd3) begin
              idx  <= idx + 2'd1;
              pins <= vec(idx + 2'd1);
            end else begin
              state  <= DONE;
              pins   <= 6'b000000;
              o_busy <= 1'b0;
              o_done <= 1'b1;
              o_pass <= ((o_fail_mask | miss) == 6'b000000);
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          o_done <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign o_pin1  = pins[0];
  assign o_pin3  = pins[1];
  assign o_pin5  = pins[2];
  assign o_pin9  = pins[3];
  assign o_pin11 = pins[4];
  assign o_pin13 = pins[5];

endmodule

// File: tb/tb_v7404_tester.sv
// Scoreboard bench for v7404_tester: a configurable inverter model answers the pins, results are queued and checked on o_done.
module tb_v7404_tester;

`ifdef V7404_TESTER_SYNC_EN
  localparam int S = 3;
`else
  localparam int S = 4;
`endif

  typedef struct packed {
    logic        pass;
    logic [5:0]  mask;
    logic [31:0] cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic o_pin1, o_pin3, o_pin5, o_pin9, o_pin11, o_pin13;
  logic i_pin2, i_pin4, i_pin6, i_pin8, i_pin10, i_pin12;
  logic busy, done, pass;
  logic [5:0] fail_mask;
  logic [5:0] drv;
  logic [5:0] resp;
  int mode = 0;
  logic [31:0] cyc = 0;
  int checks = 0;
  int failures = 0;
  exp_t sb[$];

  v7404_tester #(.SETTLE_CYCLES(S)) dut (
    .i_clk(clk), .i_reset(rst), .i_start(start),
    .o_pin1(o_pin1), .o_pin3(o_pin3), .o_pin5(o_pin5),
    .o_pin9(o_pin9), .o_pin11(o_pin11), .o_pin13(o_pin13),
    .i_pin2(i_pin2), .i_pin4(i_pin4), .i_pin6(i_pin6),
    .i_pin8(i_pin8), .i_pin10(i_pin10), .i_pin12(i_pin12),
    .o_busy(busy), .o_done(done), .o_pass(pass), .o_fail_mask(fail_mask)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Device under test model: 0 = good inverter, 1 = gate 2 stuck high, 2 = gate 5 is a buffer
  assign drv = {o_pin13, o_pin11, o_pin9, o_pin5, o_pin3, o_pin1};
  always_comb begin
    resp = ~drv;
    if (mode == 1) resp[2] = 1'b1;
    if (mode == 2) resp[5] = drv[5];
  end
  assign {i_pin12, i_pin10, i_pin8, i_pin6, i_pin4, i_pin2} = resp;

  function automatic logic [5:0] vec(input int k);
    case (k)
      0:       vec = 6'b000000;
      1:       vec = 6'b111111;
      2:       vec = 6'b010101;
      default: vec = 6'b101010;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Result monitor
  always @(negedge clk) begin
    if (!rst && done === 1'b1) begin
      exp_t e;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 expected=0 at t=%0t", $time);
      end else begin
        e = sb.pop_front();
        chk("done_pass", {31'd0, pass}, {31'd0, e.pass});
        chk("done_mask", {26'd0, fail_mask}, {26'd0, e.mask});
        chk("done_latency", cyc, e.cyc);
      end
    end
  end

  task automatic run(input int m, input logic exp_pass, input logic [5:0] exp_mask,
                     input bit abort, input bit mid_start);
    mode = m;
    @(negedge clk);
    start = 1'b1;
    if (!abort) sb.push_back('{exp_pass, exp_mask, cyc + 1 + 4 * S});
    @(negedge clk);
    start = 1'b0;
    chk("clear_pass", {31'd0, pass}, 32'd0);
    chk("clear_mask", {26'd0, fail_mask}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < S; c++) begin
        if (k > 0 || c > 0) @(negedge clk);
        start = 1'b0;
        chk($sformatf("pins_v%0d_c%0d", k, c), {26'd0, drv}, {26'd0, vec(k)});
        chk("busy_apply", {31'd0, busy}, 32'd1);
        if (mid_start && k == 1 && c == 0) start = 1'b1;
        if (abort && k == 2 && c == 1) begin
          #2 rst = 1'b1;
          #1;
          chk("abort_pins", {26'd0, drv}, 32'd0);
          chk("abort_busy", {31'd0, busy}, 32'd0);
          chk("abort_done", {31'd0, done}, 32'd0);
          chk("abort_pass", {31'd0, pass}, 32'd0);
          chk("abort_mask", {26'd0, fail_mask}, 32'd0);
          repeat (3) @(negedge clk);
          rst = 1'b0;
          @(negedge clk);
          chk("post_abort_busy", {31'd0, busy}, 32'd0);
          chk("post_abort_pins", {26'd0, drv}, 32'd0);
          return;
        end
      end
    end
    @(negedge clk);
    chk("end_pins", {26'd0, drv}, 32'd0);
    chk("end_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("idle_done", {31'd0, done}, 32'd0);
    chk("hold_pass", {31'd0, pass}, {31'd0, exp_pass});
    chk("hold_mask", {26'd0, fail_mask}, {26'd0, exp_mask});
  endtask

  initial begin
    #2 rst = 1'b1;
    #1;
    chk("rst_pins", {26'd0, drv}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_pass", {31'd0, pass}, 32'd0);
    chk("rst_mask", {26'd0, fail_mask}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_busy", {31'd0, busy}, 32'd0);
    chk("rel_pins", {26'd0, drv}, 32'd0);

    run(0, 1'b1, 6'b000000, 1'b0, 1'b0);
    run(1, 1'b0, 6'b000100, 1'b0, 1'b0);
    run(2, 1'b0, 6'b100000, 1'b0, 1'b0);
    run(0, 1'b1, 6'b000000, 1'b0, 1'b0);
    run(0, 1'b0, 6'b000000, 1'b1, 1'b0);
    run(0, 1'b1, 6'b000000, 1'b0, 1'b1);

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
